// File: rtl/reflet_timer.sv
// Down-counting bus timer with prescaler, auto-reload and sticky interrupt flag.
// Define REFLET_TIMER_PULSE_IRQ_EN to make irq a one-cycle pulse on each FLAG rise.
module reflet_timer #(
  parameter int wordsize = 16,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);
  localparam int WB = wordsize / 8;

  logic                run, auto_rl, ie, flag;
  logic [wordsize-1:0] presc, count, reload, pc;
  logic                sel;
  logic [1:0]          idx;
  logic                wr, tick, expire;
  logic [wordsize-1:0] rdata;

  // Exact match against the four register addresses; misaligned bytes never hit.
  always_comb begin
    sel = 1'b0;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (addr == base_addr + wordsize'(k * WB)) begin
        sel = 1'b1;
        idx = 2'(k);
      end
    end
  end

  assign wr     = enable & write_en & sel;
  assign tick   = enable & run & (pc == presc);
  assign expire = tick & (count == '0);

  always_comb begin
    rdata = '0;
    case (idx)
      2'd0:    rdata[3:0] = {flag, ie, auto_rl, run};
      2'd1:    rdata = presc;
      2'd2:    rdata = count;
      default: rdata = reload;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run      <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      flag     <= 1'b0;
      presc    <= '0;
      count    <= '0;
      reload   <= '0;
      pc       <= '0;
      data_out <= '0;
    end else begin
      data_out <= sel ? rdata : '0;
      if (enable) begin
        if (!run || tick) pc <= '0;
        else              pc <= pc + wordsize'(1);

        if (tick) begin
          if (count != '0)  count <= count - wordsize'(1);
          else if (auto_rl) count <= reload;
          else              run   <= 1'b0;
        end

        // An expiry on the same edge as a software clear keeps the flag set.
        if (expire)                                  flag <= 1'b1;
        else if (wr && idx == 2'd0 && data_in[3])    flag <= 1'b0;

        // Bus writes are applied last so they override tick updates.
        if (wr) begin
          case (idx)
            2'd0: begin
              run     <= data_in[0];
              auto_rl <= data_in[1];
              ie      <= data_in[2];
            end
            2'd1: begin
              presc <= data_in;
              pc    <= '0;
            end
            2'd2:    count  <= data_in;
            default: reload <= data_in;
          endcase
        end
      end
    end
  end

`ifdef REFLET_TIMER_PULSE_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= expire & ~flag & ie;
  end
`else
  assign irq = flag & ie;
`endif

endmodule
